pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised, segment-pipelined two's-complement adder/subtractor; next-generation arithmetic core of the Adder library.
//   Splits a WIDTH-bit add into SEG-bit stages with a registered carry between stages.
//   Accepts one operation per cycle through a valid/ready handshake; each op carries its own add/sub mode.
//   Reports carry-out and signed overflow for each result.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be an integer multiple of SEG (elaboration error otherwise)
//   SEG    8   bits added per pipeline stage; STAGES = WIDTH/SEG (derived localparam, >=1)
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operation offered
//   in_ready   out  1      operation accepted when in_valid && in_ready
//   sub        in   1      0: sum = a + b + cin ; 1: sum = a - b - cin
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result present
//   out_ready  in   1      result consumed when out_valid && out_ready
//   sum        out  WIDTH  result, wraps mod 2^WIDTH (see CONFIGURATION)
//   cout       out  1      carry out of MSB of internal add; for sub, 1 = no borrow
//   ovf        out  1      signed overflow of the operation
// BEHAVIOUR
//   - Internal op: x = a, y = sub ? ~b : b, c0 = sub ? ~cin : cin; {cout,sum} = x + y + c0.
//   - Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of x,y with the carry registered from stage k-1.
//     Upper operand segments are skewed forward; completed lower sum segments are deskewed, so all WIDTH bits leave together.
//   - Latency: exactly STAGES cycles from accept to out_valid with no stall; throughput 1 op/cycle.
//   - ovf = (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]); computed in the last stage.
//   - Per-stage valid bit; advance = !out_valid || out_ready; in_ready = advance (combinational).
//     On !advance the whole pipeline holds: no register changes; sum/cout/ovf stay stable while out_valid && !out_ready.
//   - Bubbles are not collapsed; ordering is strictly FIFO, with no loss or duplication.
//   - Simultaneous accept and output consume in the same cycle is legal and sustains full rate.
//   - Reset (rst_n=0, async): every valid bit = 0; out_valid=0, in_ready=1 (after reset), sum=0, cout=0, ovf=0; all datapath registers = 0.
//     Ops in flight when reset is asserted are discarded; no stale result appears after release.
//   - STAGES==1: degenerates to a single registered adder, latency 1.
//   - Inputs are sampled only on accept; a,b,sub,cin are don't-care when !in_valid.
// CONFIGURATION
//   ADDER_SAT_EN defined:
//     - In the last stage, when ovf=1, sum is replaced by the signed saturation value.
//     - The saturation value is 0x7F..F if x[MSB]==0, otherwise 0x80..0.
//     - ovf still reports 1; cout is unchanged.
//   ADDER_SAT_EN undefined: sum wraps; no saturation logic is instantiated.
// STRUCTURE
//   - Package adder_pkg holds the ADD/SUB mode encoding localparams (ADD=1'b0, SUB=1'b1) and a STAGES-derivation function.
//     Both are shared with later arithmetic blocks.
//   - One sub-module, adder_segment: an SEG-bit combinational full-adder slice (x, y, ci -> s, co).
//     It is instantiated STAGES times via generate; all pipeline registers stay in pipelined_addsub.
// TESTING  (WIDTH=8, SEG=4 => latency 2, unless noted)
//   1. add a=0xFE b=0x01 cin=0 -> after 2 cycles out_valid=1, sum=0xFF, cout=0, ovf=0.
//   2. add a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1, ovf=0 (carry crosses the segment boundary).
//   3. sub a=0x05 b=0x07 cin=0 -> sum=0xFE, cout=0 (borrow), ovf=0; sub a=0x07 b=0x05 -> sum=0x02, cout=1.
//   4. add a=0x7F b=0x01 -> ovf=1; sum=0x80 without ADDER_SAT_EN, sum=0x7F with it.
//   5. Stall: 6 back-to-back ops, out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable,
//      all 6 results delivered in order; also run the same stream at WIDTH=32/SEG=8 (latency 4).
//   6. Reset: assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately (async); after release, no output until a new op.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared arithmetic definitions: ADD/SUB mode encoding and pipeline stage-count derivation.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int stage_count(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// SEG-bit combinational full-adder slice used as one stage of pipelined_addsub.
module adder_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/pipelined_addsub.sv
// Segment-pipelined add/sub with valid/ready flow control; one SEG-bit slice per stage.
// Optional feature: define ADDER_SAT_EN to saturate the result on signed overflow.
module pipelined_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stage_count(WIDTH, SEG);
    localparam int LAST   = STAGES - 1;
    localparam int MID    = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int MSB    = WIDTH - 1;

    if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of SEG");
    end

    logic              advance;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;

    // Inter-stage registers: rank k holds the operands/partial sum leaving stage k.
    logic [WIDTH-1:0]  x_q [MID];
    logic [WIDTH-1:0]  y_q [MID];
    logic [WIDTH-1:0]  s_q [MID];
    logic              c_q [MID];

    logic [WIDTH-1:0]  st_x [STAGES];
    logic [WIDTH-1:0]  st_y [STAGES];
    logic [WIDTH-1:0]  st_s [STAGES];
    logic              st_c [STAGES];
    logic [WIDTH-1:0]  nx_s [STAGES];

    logic [STAGES-1:0][SEG-1:0] seg_s;
    logic [STAGES-1:0]          seg_co;

    logic [WIDTH-1:0]  fin_sum;
    logic              fin_ovf;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[STAGES];

    always_comb begin
        st_x[0] = a;
        st_y[0] = (sub == SUB) ? ~b : b;
        st_s[0] = '0;
        st_c[0] = (sub == SUB) ? ~cin : cin;
        for (int k = 1; k < STAGES; k++) begin
            st_x[k] = x_q[k-1];
            st_y[k] = y_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_segment #(.SEG(SEG)) u_seg (
            .x  (st_x[k][k*SEG +: SEG]),
            .y  (st_y[k][k*SEG +: SEG]),
            .ci (st_c[k]),
            .s  (seg_s[k]),
            .co (seg_co[k])
        );
    end

    // Lower segments finished earlier ride along; this stage fills in its own slice.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nx_s[k] = st_s[k];
            nx_s[k][k*SEG +: SEG] = seg_s[k];
        end
    end

    always_comb begin
        fin_ovf = (st_x[LAST][MSB] == st_y[LAST][MSB]) && (nx_s[LAST][MSB] != st_x[LAST][MSB]);
`ifdef ADDER_SAT_EN
        if (fin_ovf)
            fin_sum = st_x[LAST][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        else
            fin_sum = nx_s[LAST];
`else
        fin_sum = nx_s[LAST];
`endif
    end

    // Whole pipeline freezes when the output is blocked; bubbles leave data ranks untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            for (int k = 0; k < MID; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (advance) begin
            vld_q <= vld_pipe[STAGES-1:0];
            for (int k = 0; k < STAGES - 1; k++) begin
                if (vld_pipe[k]) begin
                    x_q[k] <= st_x[k];
                    y_q[k] <= st_y[k];
                    s_q[k] <= nx_s[k];
                    c_q[k] <= seg_co[k];
                end
            end
            if (vld_pipe[LAST]) begin
                sum  <= fin_sum;
                cout <= seg_co[LAST];
                ovf  <= fin_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: 8/4 and 32/8 instances against an arithmetic reference model with a scoreboard.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       n_iv, n_ir, n_sub, n_cin, n_ov, n_or, n_co, n_of;
    logic [7:0] n_a, n_b, n_s;
    logic        w_iv, w_ir, w_sub, w_cin, w_ov, w_or, w_co, w_of;
    logic [31:0] w_a, w_b, w_s;

    pipelined_addsub #(.WIDTH(8), .SEG(4)) u_n (
        .clk(clk), .rst_n(rst_n), .in_valid(n_iv), .in_ready(n_ir), .sub(n_sub), .cin(n_cin),
        .a(n_a), .b(n_b), .out_valid(n_ov), .out_ready(n_or), .sum(n_s), .cout(n_co), .ovf(n_of)
    );

    pipelined_addsub #(.WIDTH(32), .SEG(8)) u_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_ready(w_ir), .sub(w_sub), .cin(w_cin),
        .a(w_a), .b(w_b), .out_valid(w_ov), .out_ready(w_or), .sum(w_s), .cout(w_co), .ovf(w_of)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: exact integer arithmetic, then reduce to w bits and range-check the signed result.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin);
        res_t   r;
        longint m  = longint'(1) << w;
        longint ua = longint'(a) & (m - 1);
        longint ub = longint'(b) & (m - 1);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint ci = cin ? 1 : 0;
        longint ru = sub ? ua - ub - ci : ua + ub + ci;
        longint rs = sub ? sa - sb - ci : sa + sb + ci;
        r.cout = sub ? (ru >= 0) : (ru >= m);
        r.ovf  = (rs >= m / 2) || (rs < -(m / 2));
        r.sum  = 32'(ru & (m - 1));
`ifdef ADDER_SAT_EN
        if (r.ovf) r.sum = (rs > 0) ? 32'(m / 2 - 1) : 32'(m / 2);
`endif
        return r;
    endfunction

    res_t q_n[$];
    res_t q_w[$];
    int   dlv_n = 0;
    int   dlv_w = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q_n.delete();
            q_w.delete();
        end else begin
            if (n_ov && n_or) begin
                if (q_n.size() > 0) void'(q_n.pop_front());
                dlv_n++;
            end
            if (w_ov && w_or) begin
                if (q_w.size() > 0) void'(q_w.pop_front());
                dlv_w++;
            end
            if (n_iv && n_ir) q_n.push_back(model(8, {24'b0, n_a}, {24'b0, n_b}, n_sub, n_cin));
            if (w_iv && w_ir) q_w.push_back(model(32, w_a, w_b, w_sub, w_cin));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("n_in_ready", n_ir, !n_ov || n_or);
            chk("w_in_ready", w_ir, !w_ov || w_or);
            if (n_ov) begin
                if (q_n.size() == 0) chk("n_spurious_out", n_ov, 0);
                else begin
                    chk("n_sum", n_s, q_n[0].sum);
                    chk("n_cout", n_co, q_n[0].cout);
                    chk("n_ovf", n_of, q_n[0].ovf);
                end
            end
            if (w_ov) begin
                if (q_w.size() == 0) chk("w_spurious_out", w_ov, 0);
                else begin
                    chk("w_sum", w_s, q_w[0].sum);
                    chk("w_cout", w_co, q_w[0].cout);
                    chk("w_ovf", w_of, q_w[0].ovf);
                end
            end
        end
    end

    function automatic logic get_iv(input bit wide); return wide ? w_iv : n_iv; endfunction
    function automatic logic get_ir(input bit wide); return wide ? w_ir : n_ir; endfunction
    function automatic logic get_ov(input bit wide); return wide ? w_ov : n_ov; endfunction
    function automatic logic get_co(input bit wide); return wide ? w_co : n_co; endfunction
    function automatic logic get_of(input bit wide); return wide ? w_of : n_of; endfunction
    function automatic logic [31:0] get_s(input bit wide); return wide ? w_s : {24'b0, n_s}; endfunction
    function automatic int pending(input bit wide); return wide ? q_w.size() : q_n.size(); endfunction

    task automatic drive(input bit wide, input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin, input logic ordy);
        if (wide) begin
            w_iv = iv; w_a = a; w_b = b; w_sub = sub; w_cin = cin; w_or = ordy;
        end else begin
            n_iv = iv; n_a = a[7:0]; n_b = b[7:0]; n_sub = sub; n_cin = cin; n_or = ordy;
        end
    endtask

    function automatic logic [31:0] rnd_val(input bit wide);
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(5))
            3: v = 32'h7FFF_FFFF;
            4: v = 32'h8000_0000;
            5: v = 32'hFFFF_FFFF;
            default: ;
        endcase
        if (!wide) v = (v == 32'h7FFF_FFFF) ? 32'h7F : (v == 32'h8000_0000) ? 32'h80 : {24'b0, v[7:0]};
        return v;
    endfunction

    // Single op into an idle pipeline; checks latency and literal result. Entered/left at posedge+1.
    task automatic directed(input bit wide, input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic cin,
                            input logic [31:0] es, input logic ec, input logic eo);
        int lat = wide ? 4 : 2;
        drive(wide, 1'b1, a, b, sub, cin, 1'b1);
        @(negedge clk);
        chk({name, "_accept"}, get_ir(wide), 1);
        @(posedge clk); #1;
        drive(wide, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            chk({name, "_early"}, get_ov(wide), 0);
        end
        @(negedge clk);
        chk({name, "_valid"}, get_ov(wide), 1);
        chk({name, "_sum"}, get_s(wide), es);
        chk({name, "_cout"}, get_co(wide), ec);
        chk({name, "_ovf"}, get_of(wide), eo);
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input bit wide, input int nops, input int stall_at, input int stall_len,
                              input bit rnd);
        int    sent = 0;
        int    cyc  = 0;
        int    dlv0 = wide ? dlv_w : dlv_n;
        bit    acc;
        bit    stall;
        bit    done = 1'b0;
        string pfx  = wide ? "w" : "n";
        while (!done && cyc < 3000) begin
            stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            drive(wide, (sent < nops) && (!rnd || $urandom_range(3) != 0),
                  rnd_val(wide), rnd_val(wide), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  !stall && (!rnd || $urandom_range(2) != 0));
            @(negedge clk);
            acc = get_iv(wide) && get_ir(wide);
            if (stall && get_ov(wide)) chk({pfx, "_stall_in_ready"}, get_ir(wide), 0);
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
            done = (sent == nops) && (pending(wide) == 0);
        end
        drive(wide, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk({pfx, "_stream_drained"}, done, 1);
        chk({pfx, "_delivered"}, (wide ? dlv_w : dlv_n) - dlv0, nops);
    endtask

`ifdef ADDER_SAT_EN
    localparam logic [31:0] SAT_7F = 32'h7F;
    localparam logic [31:0] SAT_80 = 32'h80;
`else
    localparam logic [31:0] SAT_7F = 32'h80;
    localparam logic [31:0] SAT_80 = 32'h7F;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_n_out_valid", n_ov, 0);
        chk("rst_n_in_ready", n_ir, 1);
        chk("rst_n_sum", {24'b0, n_s}, 0);
        chk("rst_n_cout", n_co, 0);
        chk("rst_n_ovf", n_of, 0);
        chk("rst_w_out_valid", w_ov, 0);
        chk("rst_w_in_ready", w_ir, 1);
        chk("rst_w_sum", w_s, 0);
        chk("rst_w_cout", w_co, 0);
        chk("rst_w_ovf", w_of, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed(1'b0, "add_fe_01", 32'hFE, 32'h01, 1'b0, 1'b0, 32'hFF, 1'b0, 1'b0);
        directed(1'b0, "add_ff_01", 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
        directed(1'b0, "sub_05_07", 32'h05, 32'h07, 1'b1, 1'b0, 32'hFE, 1'b0, 1'b0);
        directed(1'b0, "sub_07_05", 32'h07, 32'h05, 1'b1, 1'b0, 32'h02, 1'b1, 1'b0);
        directed(1'b0, "add_7f_01", 32'h7F, 32'h01, 1'b0, 1'b0, SAT_7F, 1'b0, 1'b1);
        directed(1'b0, "sub_80_01", 32'h80, 32'h01, 1'b1, 1'b0, SAT_80, 1'b1, 1'b1);
        directed(1'b0, "add_0f_cin", 32'h0F, 32'h00, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        directed(1'b1, "w_add_carry3", 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        directed(1'b1, "w_add_wrap", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        directed(1'b1, "w_sub_borrow", 32'h10, 32'h10, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        run_stream(1'b0, 6, 3, 3, 1'b0);
        run_stream(1'b1, 6, 5, 3, 1'b0);
        run_stream(1'b0, 200, 40, 4, 1'b1);
        run_stream(1'b1, 200, 40, 4, 1'b1);

        // Two ops in flight, reset lands between clock edges.
        drive(1'b0, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h33, 32'h44, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_out_valid", n_ov, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", n_ov, 0);
        chk("async_rst_sum", {24'b0, n_s}, 0);
        chk("async_rst_cout", n_co, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", n_ov, 0);
        end
        @(posedge clk); #1;
        directed(1'b0, "post_rst_add", 32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
